// File: rtl/robot_ctrl_pkg.sv
// Shared definitions for the robot wall-follower controller.
//  - State codes are plain localparams so the encoding seen on state_out stays stable.
//  - cmd_t groups the three mutually exclusive movement commands.
package robot_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_DECIDE = 3'd1;
  localparam logic [STATE_W-1:0] ST_SETTLE = 3'd2;
  localparam logic [STATE_W-1:0] ST_ROT_R  = 3'd3;
  localparam logic [STATE_W-1:0] ST_REMOVE = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE   = 3'd5;

  // A right turn is realised as three left rotations.
  localparam int unsigned RIGHT_TURN_GIRARS = 3;
  localparam int unsigned ROT_W             = 2;

  typedef struct packed {
    logic avancar;
    logic girar;
    logic remover;
  } cmd_t;

endpackage

// File: rtl/robot_wall_follower_if.sv
// Robot <-> map link: sensor lines from the map, single-step commands from the robot.
//  master : robot side (reads sensors, drives commands)
//  slave  : map side   (drives sensors, reads commands)
interface robot_wall_follower_if;
  logic head;     // wall ahead
  logic left;     // wall to the robot's left
  logic under;    // robot on the black cell
  logic barrier;  // trash in the cell ahead
  logic avancar;  // move one cell forward
  logic girar;    // rotate 90 deg left
  logic remover;  // remove-trash strobe

  modport master (
    input  head, left, under, barrier,
    output avancar, girar, remover
  );

  modport slave (
    output head, left, under, barrier,
    input  avancar, girar, remover
  );
endinterface

// File: rtl/robot_wall_follower_remove_timer.sv
// Counts consecutive remover cycles and flags when the abort limit is reached.
//  ClockRobo, Reset : clock / async active-high reset
//  i_clear          : drop count to 0 (has priority)
//  i_start          : first remover cycle, count = 1
//  i_inc            : another remover cycle
//  o_at_max_c       : count equals REMOVE_MAX (combinational from the count register)
module robot_wall_follower_remove_timer #(
  parameter int unsigned REMOVE_MAX = 15,
  parameter int unsigned CNT_W      = 4
) (
  input  logic ClockRobo,
  input  logic Reset,
  input  logic i_clear,
  input  logic i_start,
  input  logic i_inc,
  output logic o_at_max_c
);

  logic [CNT_W-1:0] r_cnt;

  // Remover cycle counter
  always_ff @(posedge ClockRobo or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= CNT_W'(1);
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_at_max_c = (r_cnt == CNT_W'(REMOVE_MAX));

endmodule

// File: rtl/robot_wall_follower.sv
// Left-hand wall follower with trash removal; stops on return to the black cell.
//  ClockRobo  : robot clock (shared with the map)
//  Reset      : async active-high reset
//  Enable     : run when high, low parks the FSM in IDLE (except DONE)
//  bus        : sensor inputs / registered one-hot commands (master side)
//  done       : sticky, goal reached
//  error      : sticky, remove timeout occurred
//  step_count : saturating count of forward moves issued
//  state_out  : current state code
module robot_wall_follower
  import robot_ctrl_pkg::*;
#(
  parameter int unsigned STEP_W     = 16,
  parameter int unsigned REMOVE_MAX = 15
) (
  input  logic                   ClockRobo,
  input  logic                   Reset,
  input  logic                   Enable,
  robot_wall_follower_if.master  bus,
  output logic                   done,
  output logic                   error,
  output logic [STEP_W-1:0]      step_count,
  output logic [STATE_W-1:0]     state_out
);

  localparam int unsigned RM_CNT_W = $clog2(REMOVE_MAX + 1);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  cmd_t               r_cmd;
  cmd_t               w_cmd_nxt;
  logic               r_done;
  logic               r_error;
  logic               r_turned_left;
  logic               r_moved;
  logic [ROT_W-1:0]   r_rot_cnt;
  logic [ROT_W-1:0]   w_rot_nxt;
  logic [STEP_W-1:0]  r_step_count;
  logic               w_turned_nxt;
  logic               w_moved_nxt;
  logic               w_done_set;
  logic               w_error_set;
  logic               w_step_inc;
  logic               w_rm_clear;
  logic               w_rm_start;
  logic               w_rm_inc;
  logic               w_rm_at_max_c;

  robot_wall_follower_remove_timer #(
    .REMOVE_MAX (REMOVE_MAX),
    .CNT_W      (RM_CNT_W)
  ) u_remove_timer (
    .ClockRobo  (ClockRobo),
    .Reset      (Reset),
    .i_clear    (w_rm_clear),
    .i_start    (w_rm_start),
    .i_inc      (w_rm_inc),
    .o_at_max_c (w_rm_at_max_c)
  );

  // State and registered outputs
  always_ff @(posedge ClockRobo or posedge Reset) begin
    if (Reset) begin
      r_state       <= ST_IDLE;
      r_cmd         <= '0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_turned_left <= 1'b0;
      r_moved       <= 1'b0;
      r_rot_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd         <= w_cmd_nxt;
      r_done        <= r_done | w_done_set;
      r_error       <= r_error | w_error_set;
      r_turned_left <= w_turned_nxt;
      r_moved       <= w_moved_nxt;
      r_rot_cnt     <= w_rot_nxt;
    end
  end

  // Next-state and command decode; each command is issued on the transition into its cycle
  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_nxt    = '0;
    w_done_set   = 1'b0;
    w_error_set  = 1'b0;
    w_turned_nxt = r_turned_left;
    w_moved_nxt  = r_moved;
    w_step_inc   = 1'b0;
    w_rot_nxt    = r_rot_cnt;
    w_rm_clear   = 1'b0;
    w_rm_start   = 1'b0;
    w_rm_inc     = 1'b0;

    if (!Enable && (r_state != ST_DONE)) begin
      w_state_nxt = ST_IDLE;
      w_rot_nxt   = '0;
      w_rm_clear  = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_DECIDE;
        end

        ST_DECIDE: begin
          if (bus.under && r_moved) begin
            w_state_nxt = ST_DONE;
            w_done_set  = 1'b1;
          end else if (bus.barrier) begin
            w_state_nxt       = ST_REMOVE;
            w_cmd_nxt.remover = 1'b1;
            w_rm_start        = 1'b1;
          end else if (!bus.left && !r_turned_left) begin
            // Opening on the left: turn into it once, then must move before turning again
            w_state_nxt     = ST_SETTLE;
            w_cmd_nxt.girar = 1'b1;
            w_turned_nxt    = 1'b1;
          end else if (!bus.head) begin
            w_state_nxt       = ST_SETTLE;
            w_cmd_nxt.avancar = 1'b1;
            w_turned_nxt      = 1'b0;
            w_moved_nxt       = 1'b1;
            w_step_inc        = 1'b1;
          end else begin
            w_state_nxt     = ST_ROT_R;
            w_cmd_nxt.girar = 1'b1;
            w_rot_nxt       = ROT_W'(1);
            w_turned_nxt    = 1'b0;
          end
        end

        ST_SETTLE: begin
          if (r_rot_cnt != '0) begin
            // Remaining rotations of a right turn; counter wraps to 0 on the last one
            w_state_nxt     = ST_ROT_R;
            w_cmd_nxt.girar = 1'b1;
            w_rot_nxt       = (r_rot_cnt == ROT_W'(RIGHT_TURN_GIRARS - 1)) ?
                              '0 : r_rot_cnt + ROT_W'(1);
          end else begin
            w_state_nxt = ST_DECIDE;
          end
        end

        ST_ROT_R: begin
          w_state_nxt = ST_SETTLE;
        end

        ST_REMOVE: begin
          if (!bus.barrier) begin
            w_state_nxt = ST_SETTLE;
            w_rm_clear  = 1'b1;
          end else if (w_rm_at_max_c) begin
            w_state_nxt = ST_SETTLE;
            w_error_set = 1'b1;
            w_rm_clear  = 1'b1;
          end else begin
            w_cmd_nxt.remover = 1'b1;
            w_rm_inc          = 1'b1;
          end
        end

        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Saturating forward-move counter
  always_ff @(posedge ClockRobo or posedge Reset) begin
    if (Reset) begin
      r_step_count <= '0;
    end else if (w_step_inc && (r_step_count != '1)) begin
      r_step_count <= r_step_count + STEP_W'(1);
    end
  end

  assign bus.avancar = r_cmd.avancar;
  assign bus.girar   = r_cmd.girar;
  assign bus.remover = r_cmd.remover;
  assign done        = r_done;
  assign error       = r_error;
  assign step_count  = r_step_count;
  assign state_out   = r_state;

endmodule

// File: tb/tb_robot_wall_follower.sv
// Self-checking bench for robot_wall_follower: directed scenarios plus randomized sensor
// traffic, compared every cycle against a plan-based behavioural model of the robot.
module tb_robot_wall_follower;

  localparam int unsigned STEP_W     = 16;
  localparam int unsigned REMOVE_MAX = 15;

  localparam logic [2:0] C_NONE = 3'b000;
  localparam logic [2:0] C_AV   = 3'b100;
  localparam logic [2:0] C_GI   = 3'b010;
  localparam logic [2:0] C_RM   = 3'b001;

  typedef enum int {PH_IDLE, PH_RUN, PH_REM, PH_FIN} phase_t;

  logic              ClockRobo;
  logic              Reset;
  logic              Enable;
  logic              done;
  logic              error;
  logic [STEP_W-1:0] step_count;
  logic [2:0]        state_out;

  robot_wall_follower_if bus ();

  robot_wall_follower #(
    .STEP_W     (STEP_W),
    .REMOVE_MAX (REMOVE_MAX)
  ) dut (
    .ClockRobo  (ClockRobo),
    .Reset      (Reset),
    .Enable     (Enable),
    .bus        (bus),
    .done       (done),
    .error      (error),
    .step_count (step_count),
    .state_out  (state_out)
  );

  initial begin
    ClockRobo = 1'b0;
    forever #5 ClockRobo = ~ClockRobo;
  end

  int n_vec;
  int n_err;

  // Reference model: the robot's future command stream is kept as a plan of per-cycle outputs
  phase_t     m_phase;
  logic [2:0] plan[$];
  logic [2:0] exp_cmd;
  int         m_rm;
  int         m_steps;
  bit         m_turned;
  bit         m_moved;
  bit         m_done;
  bit         m_error;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = PH_IDLE;
    plan.delete();
    exp_cmd  = C_NONE;
    m_rm     = 0;
    m_steps  = 0;
    m_turned = 0;
    m_moved  = 0;
    m_done   = 0;
    m_error  = 0;
  endtask

  // Wall-follower rules applied at a decision point; returns the next cycle's command
  task automatic decide(output logic [2:0] nxt);
    if (bus.under && m_moved) begin
      m_done  = 1;
      m_phase = PH_FIN;
      nxt     = C_NONE;
    end else if (bus.barrier) begin
      m_phase = PH_REM;
      m_rm    = 1;
      nxt     = C_RM;
    end else if (!bus.left && !m_turned) begin
      m_turned = 1;
      nxt      = C_GI;
      plan.push_back(C_NONE);
    end else if (!bus.head) begin
      m_turned = 0;
      m_moved  = 1;
      if (m_steps < 65535) m_steps++;
      nxt = C_AV;
      plan.push_back(C_NONE);
    end else begin
      // Right turn: three rotations, each separated by a quiet cycle, then a decision
      m_turned = 0;
      nxt      = C_GI;
      plan.push_back(C_NONE);
      plan.push_back(C_GI);
      plan.push_back(C_NONE);
      plan.push_back(C_GI);
      plan.push_back(C_NONE);
      plan.push_back(C_NONE);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    logic [2:0] nxt;
    nxt = C_NONE;
    if (Reset) begin
      model_reset();
    end else if (m_phase != PH_FIN) begin
      if (!Enable) begin
        m_phase = PH_IDLE;
        plan.delete();
        m_rm = 0;
      end else if (m_phase == PH_IDLE) begin
        m_phase = PH_RUN;
      end else if (m_phase == PH_REM) begin
        if (!bus.barrier || (m_rm == REMOVE_MAX)) begin
          if (bus.barrier) m_error = 1;
          m_phase = PH_RUN;
          m_rm    = 0;
          plan.push_back(C_NONE);
        end else begin
          m_rm++;
          nxt = C_RM;
        end
      end else if (plan.size() > 0) begin
        nxt = plan.pop_front();
      end else begin
        decide(nxt);
      end
    end
    exp_cmd = nxt;
  endtask

  task automatic compare_all();
    logic [2:0] c;
    c = {bus.avancar, bus.girar, bus.remover};
    chk("cmd", 32'(c), 32'(exp_cmd));
    chk("sticky", 32'({done, error}), 32'({m_done, m_error}));
    chk("steps", 32'(step_count), 32'(m_steps));
    if (m_phase == PH_IDLE) chk("state_idle", 32'(state_out), 32'(0));
    if (m_phase == PH_FIN)  chk("state_done", 32'(state_out), 32'(5));
  endtask

  task automatic tick();
    model_step();
    @(negedge ClockRobo);
    compare_all();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset();
    Reset = 1'b1;
    #1;
    chk("rst_cmd", 32'({bus.avancar, bus.girar, bus.remover}), 32'(0));
    chk("rst_flags", 32'({done, error}), 32'(0));
    chk("rst_steps", 32'(step_count), 32'(0));
    chk("rst_state", 32'(state_out), 32'(0));
    model_reset();
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic set_sensors(input logic h, input logic l, input logic u, input logic b);
    bus.head    = h;
    bus.left    = l;
    bus.under   = u;
    bus.barrier = b;
  endtask

  int cnt;
  int hold;

  initial begin
    n_vec   = 0;
    n_err   = 0;
    Reset   = 1'b1;
    Enable  = 1'b0;
    set_sensors(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge ClockRobo);

    // Idle after reset with Enable low
    do_reset();
    for (int i = 0; i < 10; i++) tick();

    // Open left then open ahead: one left turn, then a forward move
    do_reset();
    Enable = 1'b1;
    set_sensors(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("t2_steps", 32'(step_count), 32'(1));

    // Walls left and ahead: three rotations, no forward move
    do_reset();
    Enable = 1'b1;
    set_sensors(1'b1, 1'b1, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.girar) cnt++;
    end
    chk("t3_girars", 32'(cnt), 32'(3));

    // Trash removed after 9 cycles
    do_reset();
    Enable = 1'b1;
    set_sensors(1'b1, 1'b1, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 10) bus.barrier = 1'b0;
      tick();
      if (bus.remover) cnt++;
    end
    chk("t4_remover", 32'(cnt), 32'(9));
    chk("t4_error", 32'(error), 32'(0));

    // Stuck trash: timeout after REMOVE_MAX cycles, then reset in the middle of a removal
    do_reset();
    Enable = 1'b1;
    set_sensors(1'b1, 1'b1, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (bus.remover) cnt++;
    end
    chk("t5_remover", 32'(cnt), 32'(REMOVE_MAX));
    chk("t5_error", 32'(error), 32'(1));
    for (int i = 0; i < 4; i++) tick();
    do_reset();

    // Forward move then black cell: goal reached, stays there with Enable low
    Enable = 1'b1;
    set_sensors(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    bus.under = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    Enable = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("done_sticky", 32'(done), 32'(1));

    // Randomized episodes with enable drops, trash bursts and occasional resets
    hold = 0;
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        Enable    = ($urandom % 20) != 0;
        bus.head  = $urandom % 2;
        bus.left  = $urandom % 2;
        bus.under = ($urandom % 16) == 0;
        if (hold > 0) begin
          hold--;
          bus.barrier = 1'b1;
        end else if (($urandom % 12) == 0) begin
          hold = $urandom_range(1, 20);
          bus.barrier = 1'b1;
        end else begin
          bus.barrier = 1'b0;
        end
        if (($urandom % 150) == 0) do_reset();
        else tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
